// File: rtl/bash_hash_arb.sv
// Round-robin arbiter/sequencer sharing one bash_hash core between NREQ requesters.
// Registers the owner's block onto the core, pulses prep/start, and watchdogs the core.
package bash_hash_params_pkg;
  localparam int BH_XLEN = 32;
  localparam int BH_SLEN = 64;
endpackage

module bash_hash_arb #(
  parameter int NREQ    = 2,
  parameter int XLEN    = bash_hash_params_pkg::BH_XLEN,
  parameter int SLEN    = bash_hash_params_pkg::BH_SLEN,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ-1:0]        first_i,
  input  logic [NREQ-1:0]        lock_i,
  input  logic [NREQ*16*SLEN-1:0] x_i,
  input  logic [NREQ*XLEN-1:0]   l_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic [NREQ-1:0]        done_o,
  output logic                   err_o,
  output logic [8*SLEN-1:0]      y_o,
  output logic                   core_prep_o,
  output logic                   core_start_o,
  output logic                   core_first_o,
  output logic [16*SLEN-1:0]     core_x_o,
  output logic [XLEN-1:0]        core_l_o,
  input  logic                   core_rdy_i,
  input  logic [8*SLEN-1:0]      core_y_i
);

  localparam int XW = 16*SLEN;
  localparam int YW = 8*SLEN;
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT+1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_PREP  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]      r_state;
  logic [OW-1:0]   r_last;
  logic [OW-1:0]   r_owner;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic            r_err;
  logic [YW-1:0]   r_y;
  logic            r_prep;
  logic            r_start;
  logic            r_first;
  logic [XW-1:0]   r_x;
  logic [XLEN-1:0] r_l;

  logic [OW-1:0]   w_idx;
  logic [OW-1:0]   w_win;
  logic            w_any;
  logic [NREQ-1:0] w_win_oh;
  logic [XW-1:0]   w_x_own;
  logic [XLEN-1:0] w_l_own;
  logic            w_first_own;
  logic            w_lock_own;
  logic            w_req_own;
  logic [CW-1:0]   w_cnt_nxt;

  // Walk from farthest to nearest so the requester right after r_last wins.
  always_comb begin
    w_any = 1'b0;
    w_win = r_last;
    w_idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_idx = OW'((int'(r_last) + i) % NREQ);
      if (req_i[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_win_oh    = NREQ'(1) << w_win;
  assign w_x_own     = x_i[int'(r_owner)*XW +: XW];
  assign w_l_own     = l_i[int'(r_owner)*XLEN +: XLEN];
  assign w_first_own = first_i[r_owner];
  assign w_lock_own  = lock_i[r_owner];
  assign w_req_own   = req_i[r_owner];
  assign w_cnt_nxt   = (r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_last  <= OW'(NREQ-1);
      r_owner <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_y     <= '0;
      r_prep  <= 1'b0;
      r_start <= 1'b0;
      r_first <= 1'b0;
      r_x     <= '0;
      r_l     <= '0;
    end else begin
      r_prep  <= 1'b0;
      r_start <= 1'b0;
      r_done  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_win_oh;
            r_owner <= w_win;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_x     <= w_x_own;
          r_l     <= w_l_own;
          r_first <= w_first_own;
          r_state <= w_first_own ? S_PREP : S_START;
        end
        S_PREP: begin
          r_prep  <= 1'b1;
          r_state <= S_START;
        end
        S_START: begin
          r_start <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A ready arriving on the final counted cycle still wins over the timeout.
          if (core_rdy_i) begin
            r_y     <= core_y_i;
            r_done  <= r_gnt;
            r_state <= S_DONE;
          end else begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == CW'(TIMEOUT)) begin
              r_err   <= 1'b1;
              r_gnt   <= '0;
              r_state <= S_ERR;
            end
          end
        end
        S_DONE: begin
          r_last <= r_owner;
          if (w_lock_own && w_req_own) begin
            r_state <= S_LOAD;
          end else begin
            r_gnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        S_ERR: begin
          r_gnt <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt_o        = r_gnt;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign y_o          = r_y;
  assign core_prep_o  = r_prep;
  assign core_start_o = r_start;
  assign core_first_o = r_first;
  assign core_x_o     = r_x;
  assign core_l_o     = r_l;

endmodule

// File: tb/tb_bash_hash_arb.sv
// Directed bench for bash_hash_arb: cycle table for a single transaction plus
// hand sequences for round-robin, lock bursts, watchdog and mid-flight reset.
module tb_bash_hash_arb;
  localparam int NREQ = 2, XLEN = 32, SLEN = 64, TIMEOUT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic [NREQ-1:0]         req, first, lock;
  logic [NREQ*16*SLEN-1:0] x_in;
  logic [NREQ*XLEN-1:0]    l_in;
  logic [NREQ-1:0]         gnt_o, done_o;
  logic                    err_o, core_prep_o, core_start_o, core_first_o;
  logic [8*SLEN-1:0]       y_o, core_y;
  logic [16*SLEN-1:0]      core_x_o;
  logic [XLEN-1:0]         core_l_o;
  logic                    core_rdy, tbl_rdy, model_rdy, core_en;
  int                      core_dly;

  assign core_rdy = tbl_rdy | model_rdy;

  bash_hash_arb #(.NREQ(NREQ), .XLEN(XLEN), .SLEN(SLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .first_i(first), .lock_i(lock),
    .x_i(x_in), .l_i(l_in), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .y_o(y_o),
    .core_prep_o(core_prep_o), .core_start_o(core_start_o), .core_first_o(core_first_o),
    .core_x_o(core_x_o), .core_l_o(core_l_o), .core_rdy_i(core_rdy), .core_y_i(core_y)
  );

  typedef struct {
    logic [1:0] req, first;
    logic       rdy;
    logic [6:0] exp;   // {gnt, done, prep, start, core_first}
    bit         chk_x, chk_y;
  } vec_t;
  vec_t tv [0:16];

  int n_chk = 0, n_pass = 0;
  int prep_cnt = 0, done_cnt = 0, overlap = 0;

  function automatic logic [1023:0] xblk(input int k);
    logic [1023:0] b;
    for (int w = 0; w < 16; w++) b[w*64 +: 64] = {32'hC0DE_0000 + 32'(k), 32'(w*3 + k*100 + 7)};
    return b;
  endfunction

  function automatic logic [511:0] yval();
    logic [511:0] v;
    for (int w = 0; w < 8; w++) v[w*64 +: 64] = 64'hFEED_0000_0000_0000 | 64'(w*17 + 1);
    return v;
  endfunction

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; first = '0; lock = '0; tbl_rdy = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic [1:0] d);
    d = '0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (|done_o) begin d = done_o; return; end
    end
  endtask

  task automatic wait_start(input int budget, output logic found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (core_start_o) begin found = 1'b1; return; end
    end
  endtask

  always @(negedge clk) begin
    if (core_prep_o) prep_cnt <= prep_cnt + 1;
    if (|done_o) done_cnt <= done_cnt + 1;
    if (core_prep_o && core_start_o) overlap <= overlap + 1;
  end

  // Core model: answers core_dly cycles after it sees core_start_o.
  initial begin
    model_rdy = 1'b0;
    forever begin
      tick();
      if (core_en && core_start_o) begin
        repeat (core_dly) @(posedge clk);
        #1 model_rdy = 1'b1;
        tick();
        model_rdy = 1'b0;
      end
    end
  end

  initial begin
    logic [1:0] d;
    logic       found;
    int         base;
    logic [1:0] rr_exp [0:3];

    core_en = 1'b0; core_dly = 10; tbl_rdy = 1'b0;
    x_in = {xblk(1), xblk(0)};
    l_in = {32'h0000_0200, 32'h0000_0100};
    core_y = yval();

    do_reset();
    check("rst_ctl", {gnt_o, done_o, err_o, core_prep_o, core_start_o, core_first_o}, '0);
    check("rst_x", core_x_o, '0);
    check("rst_l", core_l_o, '0);
    check("rst_y", y_o, '0);

    // Single transaction, requester 0 with prep; ready 10 cycles after start.
    for (int j = 0; j <= 16; j++) begin
      tv[j].req = 2'b01; tv[j].first = 2'b01; tv[j].rdy = 1'b0;
      tv[j].exp = {2'b01, 2'b00, 3'b001}; tv[j].chk_x = 1'b0; tv[j].chk_y = 1'b0;
    end
    tv[0].exp  = 7'b0;
    tv[1].exp  = {2'b01, 2'b00, 3'b000};
    tv[2].chk_x = 1'b1;
    tv[3].exp  = {2'b01, 2'b00, 3'b101};
    tv[4].exp  = {2'b01, 2'b00, 3'b011};
    tv[14].rdy = 1'b1;
    tv[15].exp = {2'b01, 2'b01, 3'b001};
    tv[15].chk_y = 1'b1;
    tv[16].req = 2'b00; tv[16].first = 2'b00;
    tv[16].exp = {2'b00, 2'b00, 3'b001};

    for (int j = 0; j <= 16; j++) begin
      req = tv[j].req; first = tv[j].first; tbl_rdy = tv[j].rdy;
      check($sformatf("tbl_t%0d", j),
            {gnt_o, done_o, core_prep_o, core_start_o, core_first_o}, tv[j].exp);
      if (tv[j].chk_x) begin
        check("tbl_core_x", core_x_o, xblk(0));
        check("tbl_core_l", core_l_o, 32'h0000_0100);
      end
      if (tv[j].chk_y) check("tbl_y", y_o, yval());
      tick();
    end
    tbl_rdy = 1'b0;

    // Round-robin with both requesting, no lock.
    do_reset();
    core_en = 1'b1; core_dly = 3;
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done(60, d);
      check($sformatf("rr_done%0d", k), d, rr_exp[k]);
      if (k == 0) begin
        tick();
        check("rr_idle_gap", gnt_o, 2'b00);
      end
    end
    req = '0; core_en = 1'b0;
    repeat (6) tick();

    // Lock burst: requester 1 holds the grant for three blocks.
    do_reset();
    core_en = 1'b1; core_dly = 4;
    base = prep_cnt;
    req = 2'b10; first = 2'b10; lock = 2'b10;
    tick();
    check("lk_gnt", gnt_o, 2'b10);
    req = 2'b11;
    wait_done(60, d);
    check("lk_done1", d, 2'b10);
    first = 2'b00;
    tick();
    check("lk_hold1", gnt_o, 2'b10);
    wait_done(60, d);
    check("lk_done2", d, 2'b10);
    tick();
    check("lk_hold2", gnt_o, 2'b10);
    wait_done(60, d);
    check("lk_done3", d, 2'b10);
    lock = 2'b00; req = 2'b01;
    check("lk_prep_once", prep_cnt - base, 1);
    wait_done(60, d);
    check("lk_then_r0", d, 2'b01);
    req = '0; core_en = 1'b0;
    repeat (6) tick();

    // Watchdog: core never answers.
    do_reset();
    base = done_cnt;
    req = 2'b01;
    wait_start(40, found);
    check("wd_start_seen", found, 1'b1);
    repeat (15) tick();
    check("wd_not_yet", err_o, 1'b0);
    tick();
    check("wd_err", {err_o, gnt_o}, {1'b1, 2'b00});
    repeat (100) tick();
    check("wd_sticky", {err_o, gnt_o, done_o}, {1'b1, 2'b00, 2'b00});
    check("wd_no_done", done_cnt - base, 0);

    // Watchdog boundary: ready on the last cycle before the timeout fires.
    do_reset();
    check("bd_err_cleared", err_o, 1'b0);
    req = 2'b01;
    wait_start(40, found);
    check("bd_start_seen", found, 1'b1);
    repeat (15) tick();
    tbl_rdy = 1'b1;
    tick();
    tbl_rdy = 1'b0;
    check("bd_done", {done_o, err_o}, {2'b01, 1'b0});
    check("bd_y", y_o, yval());
    req = '0;
    repeat (20) tick();
    check("bd_err_late", err_o, 1'b0);

    // Reset three cycles into WAIT.
    do_reset();
    core_en = 1'b1; core_dly = 50;
    req = 2'b01; first = 2'b01;
    wait_start(40, found);
    check("mr_start_seen", found, 1'b1);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("mr_ctl_zero", {gnt_o, done_o, err_o, core_prep_o, core_start_o, core_first_o}, '0);
    check("mr_data_zero", {core_l_o, y_o}, '0);
    rst = 1'b0; core_en = 1'b0;
    req = 2'b11; first = 2'b00;
    tick();
    check("mr_rr_r0_first", gnt_o, 2'b01);

    check("prep_start_excl", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
